// File: rtl/data_ram_lsu.sv
// Data memory for the MEM stage: MIPS-sized loads/stores, registered read, error pulse and zero-fill on reset.
// Optional board debug read port is enabled with `define RAM_DBG_PORT_EN.
module data_ram_lsu #(
  parameter int ADDR_WIDTH   = 10,
  parameter int RAM_SIZE     = 1024,
  parameter bit CLEAR_ON_RST = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic                  we,
  input  logic [2:0]            mode,
  input  logic [ADDR_WIDTH+1:0] byte_addr,
  input  logic [31:0]           wdata,
`ifdef RAM_DBG_PORT_EN
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  output logic [31:0]           dbg_data,
`endif
  output logic                  ready,
  output logic                  rvalid,
  output logic [31:0]           rdata,
  output logic                  err
);

  localparam int IDX_W = (RAM_SIZE > 1) ? $clog2(RAM_SIZE) : 1;
  localparam logic [ADDR_WIDTH:0] RANGE_LIM = (ADDR_WIDTH+1)'(RAM_SIZE);
  localparam logic [IDX_W-1:0]    CLR_LAST  = IDX_W'(RAM_SIZE - 1);

  typedef enum logic [2:0] {
    MODE_W  = 3'b000,
    MODE_H  = 3'b001,
    MODE_HU = 3'b010,
    MODE_B  = 3'b011,
    MODE_BU = 3'b100
  } mode_e;

  typedef enum logic {
    ST_CLEAR,
    ST_IDLE
  } state_e;

  state_e           state;
  logic [IDX_W-1:0] clr_ptr;

  logic [31:0] mem [RAM_SIZE];

  // Request decode
  logic [ADDR_WIDTH-1:0] word_idx;
  logic [IDX_W-1:0]      mem_idx;
  logic [1:0]            lane;
  logic                  misaligned;
  logic                  illegal;
  logic                  out_of_range;
  logic                  acc_err;
  logic                  accept;
  logic                  do_store;

  assign word_idx     = byte_addr[ADDR_WIDTH+1:2];
  assign mem_idx      = word_idx[IDX_W-1:0];
  assign lane         = byte_addr[1:0];
  assign out_of_range = ({1'b0, word_idx} >= RANGE_LIM);

  // NOTE: every signal written in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    misaligned = 1'b0;
    illegal    = 1'b0;
    case (mode)
      MODE_W:  misaligned = (lane != 2'b00);
      MODE_H:  misaligned = lane[0];
      MODE_HU: begin
        misaligned = lane[0];
        illegal    = we;
      end
      MODE_B:  illegal = 1'b0;
      MODE_BU: illegal = we;
      default: illegal = 1'b1;
    endcase
  end

  assign acc_err  = misaligned | illegal | out_of_range;
  // rst outranks a same-cycle request, even when ready is still high from IDLE
  assign accept   = req & ready & ~rst;
  assign do_store = accept & we & ~acc_err;

  // Store lane steering: right-aligned wdata replicated so each enabled byte sees its slice
  logic [3:0]  st_be;
  logic [31:0] st_data;

  always_comb begin
    st_be   = 4'b0000;
    st_data = 32'h0;
    case (mode)
      MODE_W: begin
        st_be   = 4'b1111;
        st_data = wdata;
      end
      MODE_H: begin
        st_be   = lane[1] ? 4'b1100 : 4'b0011;
        st_data = {2{wdata[15:0]}};
      end
      default: begin
        st_be   = 4'b0001 << lane;
        st_data = {4{wdata[7:0]}};
      end
    endcase
  end

  // Single write port shared by the CLEAR sweep and stores
  logic [3:0]       mem_be;
  logic [IDX_W-1:0] mem_waddr;
  logic [31:0]      mem_wdata;

  always_comb begin
    mem_be    = 4'b0000;
    mem_waddr = mem_idx;
    mem_wdata = st_data;
    if (!rst && state == ST_CLEAR) begin
      mem_be    = 4'b1111;
      mem_waddr = clr_ptr;
      mem_wdata = 32'h0;
    end else if (do_store) begin
      mem_be    = st_be;
    end
  end

  // NOTE: the array has no reset branch; zeroing is done word by word in CLEAR, which keeps it mappable to block RAM.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (mem_be[b]) begin
        mem[mem_waddr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

  // Load extension from the addressed word
  logic [31:0] rd_word;
  logic [15:0] rd_half;
  logic [7:0]  rd_byte;
  logic [31:0] load_ext;

  always_comb begin
    rd_word = mem[mem_idx];
    rd_half = lane[1] ? rd_word[31:16] : rd_word[15:0];
    case (lane)
      2'd0:    rd_byte = rd_word[7:0];
      2'd1:    rd_byte = rd_word[15:8];
      2'd2:    rd_byte = rd_word[23:16];
      default: rd_byte = rd_word[31:24];
    endcase
    case (mode)
      MODE_H:  load_ext = {{16{rd_half[15]}}, rd_half};
      MODE_HU: load_ext = {16'h0, rd_half};
      MODE_B:  load_ext = {{24{rd_byte[7]}}, rd_byte};
      MODE_BU: load_ext = {24'h0, rd_byte};
      default: load_ext = rd_word;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR_ON_RST ? ST_CLEAR : ST_IDLE;
      clr_ptr <= '0;
      ready   <= 1'b0;
      rvalid  <= 1'b0;
      err     <= 1'b0;
      rdata   <= 32'h0;
    end else begin
      rvalid <= 1'b0;
      err    <= 1'b0;
      case (state)
        ST_CLEAR: begin
          if (clr_ptr == CLR_LAST) begin
            state   <= ST_IDLE;
            ready   <= 1'b1;
            clr_ptr <= '0;
          end else begin
            clr_ptr <= clr_ptr + IDX_W'(1);
          end
        end
        default: begin
          ready <= 1'b1;
          if (accept) begin
            err <= acc_err;
            if (!we && !acc_err) begin
              rvalid <= 1'b1;
              rdata  <= load_ext;
            end
          end
        end
      endcase
    end
  end

`ifdef RAM_DBG_PORT_EN
  logic dbg_oor;
  assign dbg_oor  = ({1'b0, dbg_addr} >= RANGE_LIM);
  assign dbg_data = dbg_oor ? 32'h0 : mem[dbg_addr[IDX_W-1:0]];
`endif

endmodule

// File: tb/tb_data_ram_lsu.sv
// Directed bench for data_ram_lsu: clear timing, load/store sizing, errors, clear restart, no-clear reset.
module tb_data_ram_lsu;

  localparam int AW = 6;
  localparam int RS = 16;
  localparam logic [2:0] M_W = 3'd0, M_H = 3'd1, M_HU = 3'd2, M_B = 3'd3, M_BU = 3'd4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance with CLEAR_ON_RST=1
  logic          rst, req, we;
  logic [2:0]    mode;
  logic [AW+1:0] byte_addr;
  logic [31:0]   wdata;
  logic          ready, rvalid, err;
  logic [31:0]   rdata;

  // Instance with CLEAR_ON_RST=0
  logic          rst2, req2, we2;
  logic [2:0]    mode2;
  logic [AW+1:0] addr2;
  logic [31:0]   wdata2;
  logic          ready2, rvalid2, err2;
  logic [31:0]   rdata2;

`ifdef RAM_DBG_PORT_EN
  logic [AW-1:0] dbg_addr = '0;
  logic [31:0]   dbg_data, dbg_data2;
`endif

  int checks   = 0;
  int failures = 0;

  data_ram_lsu #(.ADDR_WIDTH(AW), .RAM_SIZE(RS), .CLEAR_ON_RST(1'b1)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .mode(mode), .byte_addr(byte_addr), .wdata(wdata),
`ifdef RAM_DBG_PORT_EN
    .dbg_addr(dbg_addr), .dbg_data(dbg_data),
`endif
    .ready(ready), .rvalid(rvalid), .rdata(rdata), .err(err)
  );

  data_ram_lsu #(.ADDR_WIDTH(AW), .RAM_SIZE(RS), .CLEAR_ON_RST(1'b0)) dut_nc (
    .clk(clk), .rst(rst2), .req(req2), .we(we2), .mode(mode2), .byte_addr(addr2), .wdata(wdata2),
`ifdef RAM_DBG_PORT_EN
    .dbg_addr(dbg_addr), .dbg_data(dbg_data2),
`endif
    .ready(ready2), .rvalid(rvalid2), .rdata(rdata2), .err(err2)
  );

  // Presents one request for one cycle (called at a negedge), returns at the next negedge
  task automatic drive(input bit sel, input logic w, input logic [2:0] m,
                       input logic [AW+1:0] a, input logic [31:0] d);
    if (!sel) begin
      req = 1'b1; we = w; mode = m; byte_addr = a; wdata = d;
    end else begin
      req2 = 1'b1; we2 = w; mode2 = m; addr2 = a; wdata2 = d;
    end
    @(negedge clk);
    req  = 1'b0;
    req2 = 1'b0;
  endtask

  task automatic test_reset;
    int cnt;
    rst = 1'b1; rst2 = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (ready !== 1'b0 || rvalid !== 1'b0 || err !== 1'b0 || rdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_state ready=%b rvalid=%b err=%b rdata=%h required 0/0/0/00000000",
               ready, rvalid, err, rdata);
    end
    rst = 1'b0; rst2 = 1'b0;
    cnt = 0;
    while (ready !== 1'b1 && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    checks++;
    if (cnt != RS) begin
      failures++;
      $display("FAIL clear_duration ready low for %0d cycles required %0d", cnt, RS);
    end
    for (int i = 0; i < RS; i++) begin
      drive(0, 1'b0, M_W, 8'(i * 4), 32'h0);
      checks++;
      if (rvalid !== 1'b1 || rdata !== 32'h0) begin
        failures++;
        $display("FAIL cleared_word%0d rvalid=%b rdata=%h required 1/00000000", i, rvalid, rdata);
      end
    end
  endtask

  task automatic test_load_store;
    logic [2:0]    lm [6] = '{M_B, M_BU, M_H, M_HU, M_W, M_B};
    logic [AW+1:0] la [6] = '{8'h04, 8'h06, 8'h06, 8'h06, 8'h04, 8'h06};
    logic [31:0]   le [6] = '{32'h00000001, 32'h000000FF, 32'hFFFF80FF,
                              32'h000080FF, 32'h80FF7F01, 32'hFFFFFFFF};
    drive(0, 1'b1, M_W, 8'h04, 32'h80FF7F01);
    checks++;
    if (rvalid !== 1'b0 || err !== 1'b0) begin
      failures++;
      $display("FAIL sw_quiet rvalid=%b err=%b required 0/0", rvalid, err);
    end
    for (int i = 0; i < 6; i++) begin
      drive(0, 1'b0, lm[i], la[i], 32'h0);
      checks++;
      if (rvalid !== 1'b1 || err !== 1'b0 || rdata !== le[i]) begin
        failures++;
        $display("FAIL load%0d mode=%0d addr=%h rvalid=%b err=%b rdata=%h required 1/0/%h",
                 i, lm[i], la[i], rvalid, err, rdata, le[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    drive(0, 1'b1, M_B, 8'h09, 32'h123456AB);
    drive(0, 1'b1, M_H, 8'h0A, 32'hFFFF1234);
    checks++;
    if (rvalid !== 1'b0 || err !== 1'b0) begin
      failures++;
      $display("FAIL b2b_stores rvalid=%b err=%b required 0/0", rvalid, err);
    end
    drive(0, 1'b0, M_W, 8'h08, 32'h0);
    checks++;
    if (rvalid !== 1'b1 || rdata !== 32'h1234AB00) begin
      failures++;
      $display("FAIL b2b_load rvalid=%b rdata=%h required 1/1234ab00", rvalid, rdata);
    end
    @(negedge clk);
    checks++;
    if (rvalid !== 1'b0 || rdata !== 32'h1234AB00) begin
      failures++;
      $display("FAIL rvalid_pulse rvalid=%b rdata=%h required 0/1234ab00", rvalid, rdata);
    end
  endtask

  task automatic test_errors;
    logic          ew [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [2:0]    em [6] = '{M_W, M_H, 3'b101, M_W, M_HU, 3'b111};
    logic [AW+1:0] ea [6] = '{8'h02, 8'h03, 8'h04, 8'h40, 8'h08, 8'h00};
    for (int i = 0; i < 6; i++) begin
      drive(0, ew[i], em[i], ea[i], 32'hCAFEF00D);
      checks++;
      if (err !== 1'b1 || rvalid !== 1'b0 || rdata !== 32'h1234AB00) begin
        failures++;
        $display("FAIL err%0d err=%b rvalid=%b rdata=%h required 1/0/1234ab00", i, err, rvalid, rdata);
      end
    end
    @(negedge clk);
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("FAIL err_pulse err=%b required 0", err);
    end
    drive(0, 1'b0, M_W, 8'h00, 32'h0);
    checks++;
    if (rvalid !== 1'b1 || rdata !== 32'h0) begin
      failures++;
      $display("FAIL err_word0 rvalid=%b rdata=%h required 1/00000000", rvalid, rdata);
    end
    drive(0, 1'b0, M_W, 8'h08, 32'h0);
    checks++;
    if (rvalid !== 1'b1 || rdata !== 32'h1234AB00) begin
      failures++;
      $display("FAIL err_word2 rvalid=%b rdata=%h required 1/1234ab00", rvalid, rdata);
    end
  endtask

  task automatic test_clear_restart;
    int cnt;
    bit quiet;
    logic [AW+1:0] ra [4] = '{8'h00, 8'h04, 8'h08, 8'h3C};
    drive(0, 1'b1, M_W, 8'h3C, 32'h11111111);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (7) @(negedge clk);
    checks++;
    if (ready !== 1'b0) begin
      failures++;
      $display("FAIL mid_clear_ready ready=%b required 0", ready);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    quiet = 1'b1;
    while (ready !== 1'b1 && cnt < 100) begin
      if (cnt == 5) begin
        req = 1'b1; we = 1'b1; mode = M_W; byte_addr = 8'h00; wdata = 32'hDEADBEEF;
      end else if (cnt == 6) begin
        req = 1'b1; we = 1'b0; mode = M_W; byte_addr = 8'h04;
      end else begin
        req = 1'b0;
      end
      cnt++;
      @(negedge clk);
      if (rvalid !== 1'b0 || err !== 1'b0) quiet = 1'b0;
    end
    req = 1'b0;
    checks++;
    if (cnt != RS) begin
      failures++;
      $display("FAIL restart_duration ready low for %0d cycles required %0d", cnt, RS);
    end
    checks++;
    if (quiet !== 1'b1) begin
      failures++;
      $display("FAIL clear_ignores_req rvalid/err seen during clear, required none");
    end
    for (int i = 0; i < 4; i++) begin
      drive(0, 1'b0, M_W, ra[i], 32'h0);
      checks++;
      if (rvalid !== 1'b1 || rdata !== 32'h0) begin
        failures++;
        $display("FAIL restart_word addr=%h rvalid=%b rdata=%h required 1/00000000", ra[i], rvalid, rdata);
      end
    end
  endtask

  task automatic test_no_clear;
    drive(1, 1'b1, M_W, 8'h10, 32'h5A5A5A5A);
    checks++;
    if (rvalid2 !== 1'b0 || err2 !== 1'b0) begin
      failures++;
      $display("FAIL nc_store rvalid=%b err=%b required 0/0", rvalid2, err2);
    end
    drive(1, 1'b0, M_W, 8'h10, 32'h0);
    rst2 = 1'b1;
    @(negedge clk);
    rst2 = 1'b0;
    checks++;
    if (ready2 !== 1'b0 || rdata2 !== 32'h0) begin
      failures++;
      $display("FAIL nc_reset ready=%b rdata=%h required 0/00000000", ready2, rdata2);
    end
    @(negedge clk);
    checks++;
    if (ready2 !== 1'b1) begin
      failures++;
      $display("FAIL nc_ready ready=%b required 1", ready2);
    end
    drive(1, 1'b0, M_W, 8'h10, 32'h0);
    checks++;
    if (rvalid2 !== 1'b1 || rdata2 !== 32'h5A5A5A5A) begin
      failures++;
      $display("FAIL nc_survive rvalid=%b rdata=%h required 1/5a5a5a5a", rvalid2, rdata2);
    end
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; we = 1'b0; mode = M_W; byte_addr = '0; wdata = '0;
    rst2 = 1'b1; req2 = 1'b0; we2 = 1'b0; mode2 = M_W; addr2 = '0; wdata2 = '0;
    test_reset();
    test_load_store();
    test_back_to_back();
    test_errors();
    test_clear_restart();
    test_no_clear();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
